// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch unit and the control decoder.
//   - opcode constants carried in inst[7:6]
//   - fetch FSM state encoding
//   - small helper to recognise the branch opcode
package instr_fetch_unit_pkg;

    localparam logic [1:0] OP_RTYPE = 2'b00;
    localparam logic [1:0] OP_LW    = 2'b01;
    localparam logic [1:0] OP_SW    = 2'b10;
    localparam logic [1:0] OP_BR    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_STOP = 2'd3
    } ifu_state_t;

    function automatic logic is_branch(input logic [1:0] op);
        return op == OP_BR;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// pc_next_calc: combinational next-PC computation.
// Ports:
//   i_pc      current PC (address of the instruction being accepted)
//   i_imm     2-bit signed branch offset (inst[1:0])
//   i_take    1 = branch taken, add sign-extended offset
//   o_pc_next pc + 1 (+ sext(imm) when taken), wraps modulo 2^PC_W
module pc_next_calc #(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic [1:0]      i_imm,
    input  logic            i_take,
    output logic [PC_W-1:0] o_pc_next
);

    logic [PC_W-1:0] w_off;

    // Sign-extend the 2-bit offset; zero when the branch is not taken.
    assign w_off     = i_take ? {{(PC_W-2){i_imm[1]}}, i_imm} : '0;
    // Truncation to PC_W bits gives the modulo wrap in both directions.
    assign o_pc_next = i_pc + PC_W'(1) + w_off;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches one instruction at a time from instruction
// memory and presents it to the decoder/datapath. Owns the PC.
// Ports:
//   clk, rst                 clock, async active-high reset
//   imem_req/imem_addr       read request and address (address = pc)
//   imem_ack/imem_rdata      read completion and instruction word
//   inst_valid/inst_ready    handshake toward the consumer
//   inst/op/pc_out           presented instruction, its opcode, its address
//   branch_cond              rs==rt from datapath, used at accept
//   halt/halted              stop request (at accept) and stopped status
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst,
    output logic [1:0]         op,
    output logic [PC_W-1:0]    pc_out,
    input  logic               branch_cond,
    input  logic               halt,
    output logic               halted
);

    ifu_state_t         r_state;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_pc_out;
    logic [INSTR_W-1:0] r_inst;
    logic               r_imem_req;
    logic               r_inst_valid;
    logic               r_halted;

    logic [1:0]         w_op;
    logic               w_take;
    logic               w_accept;
    logic [PC_W-1:0]    w_pc_next;

    assign w_op     = r_inst[INSTR_W-1 -: 2];
    assign w_take   = is_branch(w_op) & branch_cond;
    assign w_accept = r_inst_valid & inst_ready;

    pc_next_calc #(.PC_W(PC_W)) u_pc_next (
        .i_pc      (r_pc),
        .i_imm     (r_inst[1:0]),
        .i_take    (w_take),
        .o_pc_next (w_pc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_pc_out     <= '0;
            r_inst       <= '0;
            r_imem_req   <= 1'b0;
            r_inst_valid <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_REQ;
                    r_imem_req <= 1'b1;
                end
                ST_REQ: begin
                    // Request and address stay put until the memory answers.
                    if (imem_ack) begin
                        r_inst       <= imem_rdata;
                        r_pc_out     <= r_pc;
                        r_imem_req   <= 1'b0;
                        r_inst_valid <= 1'b1;
                        r_state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Acks here are stray and ignored; only accept moves on.
                    if (w_accept) begin
                        r_pc         <= w_pc_next;
                        r_inst_valid <= 1'b0;
                        if (halt) begin
                            r_halted <= 1'b1;
                            r_state  <= ST_STOP;
                        end else begin
                            r_imem_req <= 1'b1;
                            r_state    <= ST_REQ;
                        end
                    end
                end
                ST_STOP: begin
                    r_state <= ST_STOP;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_imem_req ? r_pc : '0;
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign op         = w_op;
    assign pc_out     = r_pc_out;
    assign halted     = r_halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack = 1'b0;
    logic [7:0] imem_rdata = '0;
    logic       inst_valid;
    logic       inst_ready = 1'b0;
    logic [7:0] inst;
    logic [1:0] op;
    logic [7:0] pc_out;
    logic       branch_cond = 1'b0;
    logic       halt = 1'b0;
    logic       halted;

    int checks = 0;
    int errors = 0;

    // Reference model: instruction memory image and the architectural PC.
    logic [7:0] mem [256];
    logic [7:0] mpc;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .op(op), .pc_out(pc_out),
        .branch_cond(branch_cond), .halt(halt), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},    imem_req, 0);
        chk({tag, "_addr"},   imem_addr, 0);
        chk({tag, "_valid"},  inst_valid, 0);
        chk({tag, "_inst"},   inst, 0);
        chk({tag, "_op"},     op, 0);
        chk({tag, "_pcout"},  pc_out, 0);
        chk({tag, "_halted"}, halted, 0);
    endtask

    // Called at a negedge. Acks are driven during reset and the idle cycle
    // after release; they must not produce an instruction.
    task automatic do_reset(input string tag);
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 8'hC3;
        inst_ready = 1'b0; halt = 1'b0;
        #1;
        chk_all_zero(tag);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mpc = 8'h00;
        @(negedge clk);
        imem_ack = 1'b0;
        chk({tag, "_post_valid"}, inst_valid, 0);
        chk({tag, "_post_req"},   imem_req, 1);
        chk({tag, "_post_addr"},  imem_addr, 8'h00);
    endtask

    // One full fetch/accept round trip, checked against the model.
    task automatic fetch(input int ack_dly, input int rdy_dly, input bit bc,
                         input bit h, input bit spur);
        logic [7:0] w;
        int n, off;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", imem_req, 1);
        if (imem_req !== 1'b1) return;
        chk("req_addr", imem_addr, mpc);
        for (int i = 0; i < ack_dly; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            chk("addr_stable", imem_addr, mpc);
            chk("req_held", imem_req, 1);
        end
        w = mem[mpc];
        imem_ack = 1'b1; imem_rdata = w;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = 8'($urandom);
        chk("valid", inst_valid, 1);
        chk("inst", inst, w);
        chk("op", op, w[7:6]);
        chk("pc_out", pc_out, mpc);
        chk("req_low_hold", imem_req, 0);
        inst_ready = 1'b0;
        for (int i = 0; i < rdy_dly; i++) begin
            halt = 1'($urandom_range(0, 1));
            branch_cond = 1'($urandom_range(0, 1));
            if (spur && i == 0) begin imem_ack = 1'b1; imem_rdata = ~w; end
            @(negedge clk);
            imem_ack = 1'b0;
            chk("hold_inst", inst, w);
            chk("hold_op", op, w[7:6]);
            chk("hold_pcout", pc_out, mpc);
            chk("hold_valid", inst_valid, 1);
            chk("hold_noreq", imem_req, 0);
            chk("hold_nohalt", halted, 0);
        end
        halt = h; branch_cond = bc; inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0; halt = 1'b0;
        off = 0;
        if (w[7:6] == 2'b11 && bc) off = w[1] ? int'(w[1:0]) - 4 : int'(w[1:0]);
        mpc = 8'((int'(mpc) + 1 + off) & 255);
        chk("valid_drop", inst_valid, 0);
        if (h) begin
            chk("halted", halted, 1);
            chk("halt_noreq", imem_req, 0);
            repeat (4) begin
                @(negedge clk);
                chk("stop_noreq", imem_req, 0);
                chk("stop_halted", halted, 1);
                chk("stop_novalid", inst_valid, 0);
            end
        end else begin
            chk("next_req", imem_req, 1);
            chk("next_addr", imem_addr, mpc);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mpc = 8'h00;

        // Reset and first fetch.
        @(negedge clk);
        do_reset("rst0");
        mem[0] = 8'h1B;
        fetch(0, 0, 1'b0, 1'b0, 1'b0);
        chk("t1_next", imem_addr, 8'h01);

        // Walk to 0x05 with non-branch instructions, then branch back by one.
        for (int a = 1; a < 5; a++) mem[a] = 8'h40 | 8'(a);
        for (int a = 1; a < 5; a++) fetch(0, 0, 1'b1, 1'b0, 1'b0);
        mem[5] = 8'hC3;
        fetch(0, 0, 1'b1, 1'b0, 1'b0);
        chk("t2_taken", imem_addr, 8'h05);
        fetch(1, 0, 1'b0, 1'b0, 1'b0);
        chk("t2_nottaken", imem_addr, 8'h06);

        // Wrap below zero, then wrap above 0xFF.
        @(negedge clk);
        do_reset("rst1");
        mem[0] = 8'hC2;
        fetch(0, 0, 1'b1, 1'b0, 1'b0);
        chk("t3_wrap_dn", imem_addr, 8'hFF);
        mem[8'hFF] = 8'h7E;
        fetch(0, 0, 1'b1, 1'b0, 1'b0);
        chk("t3_wrap_up", imem_addr, 8'h00);

        // Consumer back-pressure, then slow memory with a stray ack in HOLD.
        fetch(0, 5, 1'b0, 1'b0, 1'b0);
        fetch(3, 2, 1'b0, 1'b0, 1'b1);

        // Randomized run.
        for (int k = 0; k < 40; k++)
            fetch($urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));

        // Reset while requesting.
        do_reset("rst_req");
        // Reset while holding an instruction.
        imem_ack = 1'b1; imem_rdata = mem[mpc];
        @(negedge clk);
        imem_ack = 1'b0;
        chk("pre_rst_valid", inst_valid, 1);
        do_reset("rst_hold");

        // Halt at accept.
        fetch(0, 1, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
